// File: rtl/axis_1553_encoder.sv
// AXI-Stream to MIL-STD-1553 Manchester II encoder: 3-bit-time sync, 16 data bits MSB first, odd parity.
// Optional macro AXIS_1553_ENC_PARITY_ERR_EN: tuser[0] inverts the transmitted parity bit.
`timescale 1ns/1ps
module axis_1553_encoder #(
    parameter int CLOCK_SPEED = 100000000
) (
    input  logic        aclk,
    input  logic        arstn,
    input  logic [15:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic [7:0]  s_axis_tuser,
    output logic        s_axis_tready,
    output logic [1:0]  diff
);
    localparam int CPB = CLOCK_SPEED / 1000000;
    localparam int HB  = CPB / 2;
    localparam int CW  = (HB > 1) ? $clog2(HB) : 1;

    typedef enum logic [1:0] {IDLE, SYNC, DATA, PARITY} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] hb_cnt_reg, hb_cnt_next;
    logic [5:0]    hb_idx_reg, hb_idx_next;
    logic [15:0]   data_reg, data_next;
    logic          cmd_reg, cmd_next;
    logic          par_reg, par_next;
    logic [1:0]    diff_reg, diff_next;
    logic          en_reg;
    logic          last_cycle, ready, accept, level, par_calc;
    logic [3:0]    bit_sel;

`ifdef AXIS_1553_ENC_PARITY_ERR_EN
    logic unused_tuser;
    assign unused_tuser = ^s_axis_tuser[6:1];
    assign par_calc     = ~^s_axis_tdata ^ s_axis_tuser[0];
`else
    logic unused_tuser;
    assign unused_tuser = ^s_axis_tuser[6:0];
    assign par_calc     = ~^s_axis_tdata;
`endif

    // en_reg keeps tready low while reset is held and opens it on the first edge after release.
    assign last_cycle    = (state_reg == PARITY) && (hb_idx_reg == 6'd39) && (hb_cnt_reg == CW'(HB - 1));
    assign ready         = en_reg && ((state_reg == IDLE) || last_cycle);
    assign accept        = ready && s_axis_tvalid;
    assign s_axis_tready = ready;
    assign diff          = diff_reg;

    always_comb begin
        state_next  = state_reg;
        hb_cnt_next = hb_cnt_reg;
        hb_idx_next = hb_idx_reg;
        data_next   = data_reg;
        cmd_next    = cmd_reg;
        par_next    = par_reg;
        level       = 1'b1;
        bit_sel     = 4'd0;
        diff_next   = 2'b11;

        if (accept) begin
            data_next   = s_axis_tdata;
            cmd_next    = s_axis_tuser[7];
            par_next    = par_calc;
            hb_cnt_next = '0;
            hb_idx_next = 6'd0;
            state_next  = SYNC;
        end else if (last_cycle) begin
            hb_cnt_next = '0;
            hb_idx_next = 6'd0;
            state_next  = IDLE;
        end else if (state_reg != IDLE) begin
            if (hb_cnt_reg == CW'(HB - 1)) begin
                hb_cnt_next = '0;
                hb_idx_next = hb_idx_reg + 6'd1;
            end else begin
                hb_cnt_next = hb_cnt_reg + CW'(1);
            end
            if (hb_idx_next < 6'd6)
                state_next = SYNC;
            else if (hb_idx_next < 6'd38)
                state_next = DATA;
            else
                state_next = PARITY;
        end

        // diff is computed one cycle ahead from the position the frame will be in next cycle.
        if (state_next != IDLE) begin
            if (hb_idx_next < 6'd3) begin
                level = cmd_next;
            end else if (hb_idx_next < 6'd6) begin
                level = ~cmd_next;
            end else if (hb_idx_next < 6'd38) begin
                // data bit index is 15 - (idx/2 - 3), i.e. 18 - idx/2, taken modulo 16
                bit_sel = 4'd2 - hb_idx_next[4:1];
                level   = data_next[bit_sel] ^ hb_idx_next[0];
            end else begin
                level = par_next ^ hb_idx_next[0];
            end
            diff_next = {level, ~level};
        end
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_reg  <= IDLE;
            hb_cnt_reg <= '0;
            hb_idx_reg <= 6'd0;
            data_reg   <= 16'd0;
            cmd_reg    <= 1'b0;
            par_reg    <= 1'b0;
            diff_reg   <= 2'b11;
            en_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            hb_cnt_reg <= hb_cnt_next;
            hb_idx_reg <= hb_idx_next;
            data_reg   <= data_next;
            cmd_reg    <= cmd_next;
            par_reg    <= par_next;
            diff_reg   <= diff_next;
            en_reg     <= 1'b1;
        end
    end
endmodule
